// File: rtl/pattern_player.sv
// pattern_player
//   Stimulus sequencer. Plays back a DEPTH x WIDTH pattern table, holding
//   each entry for max(hold,1) clocks, one-shot or looping, with a
//   start/stop/done handshake. The table is written through wr_* while idle.
//
//   Optional build macro: PATTERN_PLAYER_TOGGLE_EN
//     adds the tog[1:0] output and a HALF-clock period counter.
//     tog[0] inverts every HALF clocks and tog[1] every 2*HALF clocks
//     while busy.
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   wr_en     table write strobe (honoured only while idle)
//   wr_addr   table write address
//   wr_data   table write data
//   hold      clocks per pattern (0 is treated as 1), latched on start
//   last_idx  final index of a pass, latched on start
//   loop      1 = wrap to index 0 after last_idx (sampled at pass end)
//   start     begin playback
//   stop      abort playback (wins over start and over end-of-pattern)
//   dout      current pattern
//   idx       index of current pattern
//   busy      playback in progress
//   done      one-clock pulse at the normal end of a one-shot pass
//   tog       periodic outputs (toggle build only)
module pattern_player #(
  parameter int WIDTH  = 6,
  parameter int AW     = 2,
  parameter int HOLD_W = 8,
  parameter int HALF   = 50
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [HOLD_W-1:0] hold,
  input  logic [AW-1:0]     last_idx,
  input  logic              loop,
  input  logic              start,
  input  logic              stop,
  output logic [WIDTH-1:0]  dout,
  output logic [AW-1:0]     idx,
  output logic              busy,
  output logic              done
`ifdef PATTERN_PLAYER_TOGGLE_EN
  ,
  output logic [1:0]        tog
`endif
);

  localparam int DEPTH = 2**AW;

  if (HALF < 1) begin : g_bad_half
    $error("pattern_player: HALF must be >= 1");
  end

  typedef enum logic {IDLE, PLAY} state_t;

  state_t              state, state_d;
  logic [WIDTH-1:0]    mem [DEPTH];
  logic [WIDTH-1:0]    dout_q;
  logic [AW-1:0]       idx_q, last_q, idx_nx;
  logic [HOLD_W-1:0]   cnt, hold_q, hold_m1;
  logic                done_q;
  logic                load, step, wrap, finish;

  // Reload value is max(hold,1)-1 so the counter's zero marks the last
  // clock of the current pattern.
  assign hold_m1 = (hold == '0) ? '0 : hold - HOLD_W'(1);
  assign idx_nx  = idx_q + AW'(1);

  // ---------------- FSM next-state / event decode ----------------
  always_comb begin
    state_d = state;
    load    = 1'b0;
    step    = 1'b0;
    wrap    = 1'b0;
    finish  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !stop) begin
          state_d = PLAY;
          load    = 1'b1;
        end
      end
      PLAY: begin
        if (stop) begin
          state_d = IDLE;
        end else if (cnt == '0) begin
          if (idx_q < last_q) step = 1'b1;
          else if (loop)      wrap = 1'b1;
          else begin
            finish  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // ---------------- table ----------------
  // Not reset; writes are locked out during playback so the pass being
  // played cannot change underneath dout.
  always_ff @(posedge clk) begin
    if (wr_en && state == IDLE) mem[wr_addr] <= wr_data;
  end

  // ---------------- playback datapath ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= '0;
      idx_q  <= '0;
      last_q <= '0;
      hold_q <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= finish;
      if (load) begin
        idx_q  <= '0;
        dout_q <= mem[0];
        cnt    <= hold_m1;
        hold_q <= hold_m1;
        last_q <= last_idx;
      end else if (step) begin
        idx_q  <= idx_nx;
        dout_q <= mem[idx_nx];
        cnt    <= hold_q;
      end else if (wrap) begin
        idx_q  <= '0;
        dout_q <= mem[0];
        cnt    <= hold_q;
      end else if (state == PLAY && !stop && cnt != '0) begin
        cnt <= cnt - HOLD_W'(1);
      end
    end
  end

  assign dout = dout_q;
  assign idx  = idx_q;
  assign busy = (state == PLAY);
  assign done = done_q;

`ifdef PATTERN_PLAYER_TOGGLE_EN
  // ---------------- periodic toggles ----------------
  localparam int TW = (HALF > 1) ? $clog2(HALF) : 1;

  logic [TW-1:0] tcnt;

  // tog[1] flips whenever tog[0] falls, giving twice tog[0]'s period.
  always_ff @(posedge clk) begin
    if (rst) begin
      tog  <= 2'b00;
      tcnt <= '0;
    end else if (load) begin
      tog  <= 2'b00;
      tcnt <= '0;
    end else if (state == PLAY) begin
      if (tcnt == TW'(HALF - 1)) begin
        tcnt   <= '0;
        tog[0] <= ~tog[0];
        if (tog[0]) tog[1] <= ~tog[1];
      end else begin
        tcnt <= tcnt + TW'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_pattern_player.sv
// Self-checking bench for pattern_player. Expected outputs come from a
// time-since-start model: pattern index = floor(t/hold) for a pass.
module tb_pattern_player;
  localparam int W    = 6;
  localparam int AW   = 2;
  localparam int HW   = 8;
  localparam int HALF = 50;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [W-1:0]  wr_data = '0;
  logic [HW-1:0] hold = '0;
  logic [AW-1:0] last_idx = '0;
  logic          loop = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [W-1:0]  dout;
  logic [AW-1:0] idx;
  logic          busy;
  logic          done;
`ifdef PATTERN_PLAYER_TOGGLE_EN
  logic [1:0]    tog;
`endif

  always #5 clk = ~clk;

  pattern_player #(.WIDTH(W), .AW(AW), .HOLD_W(HW), .HALF(HALF)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .hold(hold), .last_idx(last_idx), .loop(loop), .start(start), .stop(stop),
    .dout(dout), .idx(idx), .busy(busy), .done(done)
`ifdef PATTERN_PLAYER_TOGGLE_EN
    , .tog(tog)
`endif
  );

  int total  = 0;
  int passed = 0;
  logic [W-1:0] ref_mem [4];
  wire  [W+AW+1:0] obs = {busy, done, idx, dout};

  // {busy, done, idx, dout} expected t clocks after the start edge.
  function automatic logic [W+AW+1:0] expect_at(int t, int h, int last, bit lp);
    int hh = (h == 0) ? 1 : h;
    int n  = last + 1;
    int pl = hh * n;
    logic [AW-1:0] ia;
    if (lp || t < pl) begin
      ia = AW'((t / hh) % n);
      return {1'b1, 1'b0, ia, ref_mem[ia]};
    end
    ia = AW'(last);
    return {1'b0, (t == pl), ia, ref_mem[ia]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_entry(input int a, input logic [W-1:0] d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
    tick();
    wr_en = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic start_play(input int h, input int last, input bit lp);
    hold = HW'(h); last_idx = AW'(last); loop = lp; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick();
    total++;
    if (obs !== '0) $display("FAIL reset_init got %h want 0", obs); else passed++;
`ifdef PATTERN_PLAYER_TOGGLE_EN
    total++;
    if (tog !== 2'b00) $display("FAIL reset_tog got %b want 00", tog); else passed++;
`endif
    rst = 1'b0;
    for (int a = 0; a < 4; a++) load_entry(a, W'($urandom));
    start_play(3, 3, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1; tick();
    total++;
    if (obs !== '0) $display("FAIL reset_mid1 got %h want 0", obs); else passed++;
    tick(); rst = 1'b0; tick();
    total++;
    if (obs !== '0) $display("FAIL reset_after got %h want 0", obs); else passed++;
  endtask

  task automatic test_oneshot();
    int ndone = 0;
    load_entry(0, 6'b011001); load_entry(1, 6'b011011);
    load_entry(2, 6'b011000); load_entry(3, 6'b001000);
    start_play(10, 3, 1'b0);
    for (int t = 0; t <= 45; t++) begin
      if (t > 0) tick();
      start = (t == 15);           // start while busy must be ignored
      if (t == 5) begin hold = 8'd3; last_idx = 2'd1; end  // latched values rule
      if (done) ndone++;
      total++;
      if (obs !== expect_at(t, 10, 3, 1'b0))
        $display("FAIL oneshot t=%0d got %h want %h", t, obs, expect_at(t, 10, 3, 1'b0));
      else passed++;
    end
    start = 1'b0;
    total++;
    if (ndone != 1) $display("FAIL oneshot_done_count got %0d want 1", ndone); else passed++;
    total++;
    if (dout !== 6'b001000) $display("FAIL oneshot_final got %b want 001000", dout); else passed++;
  endtask

  task automatic test_loop_hold0();
    logic [W+AW+1:0] e;
    start_play(0, 1, 1'b1);
    for (int t = 0; t <= 7; t++) begin
      if (t > 0) tick();
      if (t <= 5)      e = expect_at(t, 0, 1, 1'b1);
      else if (t == 6) e = {1'b1 ^ 1'b1, 1'b1, 2'd1, ref_mem[1]};
      else             e = {1'b0, 1'b0, 2'd1, ref_mem[1]};
      total++;
      if (obs !== e) $display("FAIL loop_hold0 t=%0d got %h want %h", t, obs, e);
      else passed++;
      if (t == 4) loop = 1'b0;     // idx=0 now; pass ends after the next idx=1
    end
  endtask

  task automatic test_stop();
    logic [W-1:0] newv;
    logic [W+AW+1:0] e;
    start_play(10, 3, 1'b0);
    for (int t = 1; t <= 24; t++) tick();
    // stop during the 5th clock of pattern 2, plus a write that must be ignored
    stop = 1'b1; wr_en = 1'b1; wr_addr = 2'd0; wr_data = ~ref_mem[0];
    tick();
    stop = 1'b0; wr_en = 1'b0;
    e = {1'b0, 1'b0, 2'd2, ref_mem[2]};
    total++;
    if (obs !== e) $display("FAIL stop_next got %h want %h", obs, e); else passed++;
    tick(); tick();
    total++;
    if (obs !== e) $display("FAIL stop_frozen got %h want %h", obs, e); else passed++;
    // idle write to the shown entry must not change dout
    newv = ~ref_mem[2];
    load_entry(2, newv);
    total++;
    if (obs !== e) $display("FAIL idle_write_dout got %h want %h", obs, e); else passed++;
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    total++;
    if (busy !== 1'b0) $display("FAIL start_stop_idle got %b want 0", busy); else passed++;
    start_play(2, 2, 1'b0);
    for (int t = 0; t <= 7; t++) begin
      if (t > 0) tick();
      e = expect_at(t, 2, 2, 1'b0);
      total++;
      if (obs !== e) $display("FAIL stop_readback t=%0d got %h want %h", t, obs, e);
      else passed++;
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int h, l, pl;
      for (int a = 0; a < 4; a++) load_entry(a, W'($urandom));
      h = $urandom_range(0, 4); l = $urandom_range(0, 3);
      pl = ((h == 0) ? 1 : h) * (l + 1);
      start_play(h, l, 1'b0);
      for (int t = 0; t <= pl + 1; t++) begin
        if (t > 0) tick();
        hold = HW'($urandom); last_idx = AW'($urandom);
        total++;
        if (obs !== expect_at(t, h, l, 1'b0))
          $display("FAIL random it=%0d t=%0d got %h want %h", it, t, obs, expect_at(t, h, l, 1'b0));
        else passed++;
      end
    end
  endtask

  task automatic test_back_to_back();
    int h1 = 2, l1 = 1, h2 = 3, l2 = 2;
    int pl1 = h1 * (l1 + 1);
    int pl2 = h2 * (l2 + 1);
    start_play(h1, l1, 1'b0);
    for (int t = 1; t <= pl1; t++) tick();
    total++;
    if (obs !== expect_at(pl1, h1, l1, 1'b0))
      $display("FAIL b2b_done got %h want %h", obs, expect_at(pl1, h1, l1, 1'b0));
    else passed++;
    start_play(h2, l2, 1'b0);      // start sampled while done is high
    for (int t = 0; t <= pl2 + 1; t++) begin
      if (t > 0) tick();
      total++;
      if (obs !== expect_at(t, h2, l2, 1'b0))
        $display("FAIL b2b t=%0d got %h want %h", t, obs, expect_at(t, h2, l2, 1'b0));
      else passed++;
    end
  endtask

`ifdef PATTERN_PLAYER_TOGGLE_EN
  task automatic test_toggle();
    logic [1:0] et;
    start_play(255, 3, 1'b1);
    for (int t = 0; t <= 450; t++) begin
      if (t > 0) tick();
      et[0] = ((t / HALF) % 2) != 0;
      et[1] = ((t / (2 * HALF)) % 2) != 0;
      total++;
      if (tog !== et) $display("FAIL toggle t=%0d got %b want %b", t, tog, et);
      else passed++;
    end
    stop = 1'b1; tick(); stop = 1'b0;
    et[0] = ((451 / HALF) % 2) != 0;
    et[1] = ((451 / (2 * HALF)) % 2) != 0;
    for (int i = 0; i < 120; i++) tick();
    total++;
    if (tog !== et) $display("FAIL toggle_frozen got %b want %b", tog, et); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_oneshot();
    test_loop_hold0();
    test_stop();
    test_random();
    test_back_to_back();
`ifdef PATTERN_PLAYER_TOGGLE_EN
    test_toggle();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
